// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM with byte strobes, 1- or 2-cycle registered reads, read-during-write
// collision flag and a post-reset zeroing sweep that gates traffic through `ready`.
module dual_port_ram_pipe #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     wr_add,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     in,
    input  logic                  rd,
    input  logic [ADDR_W-1:0]     rd_add,
    output logic [DATA_W-1:0]     out,
    output logic                  rd_valid,
    output logic                  collision,
    output logic                  ready
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clr_we;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_wdata;

    logic                wr_fire, rd_fire, wr_in, rd_in, coll;
    logic [DATA_W-1:0]   rd_word, rd_data;

    logic                s1_valid_q, s1_valid_d, s1_coll_q, s1_coll_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: the sweep leaves INIT right after writing the last location
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (INIT_CLEAR == 0 || cnt_q == LAST_ADDR) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        clr_we = (state_q == S_INIT) && (INIT_CLEAR != 0);
        ready  = (state_q == S_RUN);
        cnt_d  = clr_we ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        wr_fire = wr && ready;
        rd_fire = rd && ready;
        wr_in   = int'(wr_add) < DEPTH;
        rd_in   = int'(rd_add) < DEPTH;
        coll    = rd_fire && rd_in && wr_fire && (rd_add == wr_add);
        rd_word = (rd_fire && rd_in) ? mem_q[rd_add] : '0;
        for (int i = 0; i < NB; i++) begin
            rd_data[8*i +: 8] = (BYPASS != 0 && coll && wr_be[i]) ? in[8*i +: 8] : rd_word[8*i +: 8];
        end
        s1_valid_d = rd_fire;
        s1_coll_d  = coll;
        s1_data_d  = rd_fire ? rd_data : '0;
    end

    // The sweep and user writes share one write port; they never overlap because ready=0 in INIT
    always_comb begin
        mem_we    = clr_we || (wr_fire && wr_in);
        mem_addr  = clr_we ? cnt_q : wr_add;
        mem_be    = clr_we ? '1 : wr_be;
        mem_wdata = clr_we ? '0 : in;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_coll_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_coll_q  <= s1_coll_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_coll_q;
            logic [DATA_W-1:0] s2_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_coll_q  <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_coll_q  <= s1_coll_q;
                    s2_data_q  <= s1_data_q;
                end
            end

            assign out       = s2_data_q;
            assign rd_valid  = s2_valid_q;
            assign collision = s2_coll_q;
        end else begin : g_lat1
            assign out       = s1_data_q;
            assign rd_valid  = s1_valid_q;
            assign collision = s1_coll_q;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Bench for dual_port_ram_pipe: two instances (DEPTH 16/RD_LAT 1/no bypass and
// DEPTH 12/RD_LAT 2/bypass) share stimulus; a queue-based monitor checks every output cycle.
module tb_dual_port_ram_pipe;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int NB = 8;
    localparam int EW = 81;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr, rd;
    logic [AW-1:0] wr_add, rd_add;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] in_d;
    logic [DW-1:0] out_a, out_b;
    logic          rv_a, rv_b, col_a, col_b, rdy_a, rdy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ka, kb;

    logic [DW-1:0] mdl_a [16];
    logic [DW-1:0] mdl_b [16];
    logic [EW-1:0] exp_a_q [$];
    logic [EW-1:0] exp_b_q [$];

    dual_port_ram_pipe #(.DATA_W(DW), .DEPTH(16), .RD_LAT(1), .INIT_CLEAR(1), .BYPASS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .in(in_d),
        .rd(rd), .rd_add(rd_add), .out(out_a), .rd_valid(rv_a), .collision(col_a), .ready(rdy_a)
    );

    dual_port_ram_pipe #(.DATA_W(DW), .DEPTH(12), .RD_LAT(2), .INIT_CLEAR(1), .BYPASS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .in(in_d),
        .rd(rd), .rd_add(rd_add), .out(out_b), .rd_valid(rv_b), .collision(col_b), .ready(rdy_b)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) if (be[i]) mask = mask | (64'hFF << (8 * i));
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
    endfunction

    // one cycle of stimulus; expectations pushed with the cycle they must appear on
    task automatic op(input logic w, input int wa, input logic [7:0] be, input logic [63:0] d,
                      input logic r, input int ra);
        logic [63:0] ea, eb;
        logic        ca, cb;
        @(negedge clk);
        wr = w; wr_add = AW'(wa); wr_be = be; in_d = d;
        rd = r; rd_add = AW'(ra);
        if (r) begin
            ca = w && (wa == ra);
            ea = mdl_a[ra];
            exp_a_q.push_back({16'(cyc + 1), ca, ea});
            if (ra >= 12) begin
                cb = 1'b0;
                eb = '0;
            end else begin
                cb = w && (wa == ra);
                eb = cb ? merge(mdl_b[ra], d, be) : mdl_b[ra];
            end
            exp_b_q.push_back({16'(cyc + 2), cb, eb});
        end
        if (w) begin
            mdl_a[wa] = merge(mdl_a[wa], d, be);
            if (wa < 12) mdl_b[wa] = merge(mdl_b[wa], d, be);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 0, 8'h00, 64'h0, 1'b0, 0);
    endtask

    // counts edges from reset release to ready, poking wr/rd early in the sweep
    task automatic wait_ready(output int ra_k, output int rb_k);
        ra_k = -1;
        rb_k = -1;
        for (int k = 1; k <= 40 && (ra_k < 0 || rb_k < 0); k++) begin
            @(posedge clk);
            #1;
            if (rdy_a && ra_k < 0) ra_k = k;
            if (rdy_b && rb_k < 0) rb_k = k;
            if (k <= 9) begin
                wr     = 1'($urandom_range(0, 1));
                rd     = 1'($urandom_range(0, 1));
                wr_add = AW'($urandom_range(0, 15));
                rd_add = AW'($urandom_range(0, 15));
                wr_be  = 8'hFF;
                in_d   = {$urandom, $urandom} | 64'h1;
            end else begin
                wr = 1'b0;
                rd = 1'b0;
            end
        end
        wr = 1'b0;
        rd = 1'b0;
    endtask

    // monitor: pop when an expectation is due, otherwise the output must be idle and zero
    task automatic mon(input int which, input logic v, input logic [63:0] o, input logic c);
        logic [EW-1:0] e;
        bit            due;
        string         id;
        id  = (which == 0) ? "a" : "b";
        due = 1'b0;
        if (which == 0 && exp_a_q.size() > 0 && int'(exp_a_q[0][80:65]) == cyc) begin
            e = exp_a_q.pop_front();
            due = 1'b1;
        end
        if (which == 1 && exp_b_q.size() > 0 && int'(exp_b_q[0][80:65]) == cyc) begin
            e = exp_b_q.pop_front();
            due = 1'b1;
        end
        if (due) begin
            check($sformatf("rd_valid_%s", id), 64'(v), 64'd1);
            check($sformatf("out_%s", id), o, e[63:0]);
            check($sformatf("collision_%s", id), 64'(c), 64'(e[64]));
        end else begin
            check($sformatf("idle_valid_%s", id), 64'(v), 64'd0);
            check($sformatf("idle_out_%s", id), o, 64'd0);
            check($sformatf("idle_collision_%s", id), 64'(c), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv_a, out_a, col_a);
        mon(1, rv_b, out_b, col_b);
    end

    initial begin
        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; wr_add = '0; rd_add = '0; wr_be = '0; in_d = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(ka, kb);
        check("ready_latency_a", 64'(ka), 64'd16);
        check("ready_latency_b", 64'(kb), 64'd12);

        for (int a = 0; a < 16; a++) op(1'b0, 0, 8'h00, 64'h0, 1'b1, a);

        op(1'b1, 5, 8'hFF, 64'h1122334455667788, 1'b0, 0);
        op(1'b1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 0);
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 5);

        op(1'b1, 3, 8'hF0, 64'hFFFF0000FFFF0000, 1'b1, 3);
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 3);

        op(1'b1, 13, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, 0);
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 13);
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 1);

        op(1'b1, 7, 8'h00, 64'h123456789ABCDEF0, 1'b0, 0);
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 7);
        idle(2);

        for (int i = 0; i < 8; i++) op(1'b0, 0, 8'h00, 64'h0, 1'b1, $urandom_range(0, 15));
        idle(2);

        for (int i = 0; i < 400; i++) begin
            int wa, ra;
            wa = $urandom_range(0, 15);
            ra = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15);
            op(1'($urandom_range(0, 1)), wa, 8'($urandom), {$urandom, $urandom},
               1'($urandom_range(0, 1)), ra);
        end
        idle(3);

        // reset while the 2-cycle read is still inside the pipeline
        op(1'b0, 0, 8'h00, 64'h0, 1'b1, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
        model_clear();
        #1;
        check("reset_ready_a", 64'(rdy_a), 64'd0);
        check("reset_ready_b", 64'(rdy_b), 64'd0);
        check("reset_valid_b", 64'(rv_b), 64'd0);
        check("reset_out_a", out_a, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(ka, kb);
        check("ready_latency_again_a", 64'(ka), 64'd16);
        check("ready_latency_again_b", 64'(kb), 64'd12);
        for (int a = 0; a < 16; a++) op(1'b0, 0, 8'h00, 64'h0, 1'b1, a);
        idle(4);

        check("pending_a", 64'(exp_a_q.size()), 64'd0);
        check("pending_b", 64'(exp_b_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
